// File: rtl/ifetch_unit.sv
// ifetch_unit
// Instruction fetch stage. Reads a byte-wide instruction memory one byte
// per cycle, assembles big-endian 32-bit words (lowest address in 31:24),
// buffers up to DEPTH words with their PCs, and presents them to the
// datapath over a valid/ready handshake. A redirect loads a new fetch PC
// and flushes all buffered and in-flight work.
//
// Ports
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   im_rd        byte read strobe to instruction memory
//   im_addr      byte address of this cycle's read
//   im_rdata     read data, valid the cycle after im_rd
//   inst         instruction at queue head
//   inst_pc      byte PC of inst
//   inst_valid   queue non-empty
//   inst_ready   consumer accepts head word when inst_valid & inst_ready
//   redirect     load redirect_pc as the new fetch PC and flush
//   redirect_pc  redirect target, bits 1:0 ignored
//
// FSM states
//   state     | meaning
//   ST_ISSUE  | issuing byte reads (or ready to start a new word)
//   ST_WAIT   | no credit left; idle until a pop frees a queue slot
module ifetch_unit #(
  parameter int          ADDR_W   = 5,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              im_rd,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [7:0]        im_rdata,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_WAIT  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic            run;
  logic [31:0]     fpc;
  logic [1:0]      bcnt;
  logic [CW-1:0]   credit, credit_nxt;
  logic            drop;
  logic [23:0]     sr;
  logic            rd_q;
  logic [1:0]      rd_idx;
  logic [31:0]     word_pc;

  logic [31:0]     q_inst [DEPTH];
  logic [31:0]     q_pc   [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;

  logic            issue_b0;
  logic            pop;
  logic            accept;
  logic            push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else return p + PW'(1);
  endfunction

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? q_inst[head] : 32'h0;
  assign inst_pc    = inst_valid ? q_pc[head]   : 32'h0;
  assign im_addr    = run ? (fpc[ADDR_W-1:0] + ADDR_W'(bcnt)) : '0;

  assign pop      = inst_valid & inst_ready;
  assign issue_b0 = im_rd & (bcnt == 2'd0);
  // drop kills the byte returning for the issue made in the redirect cycle
  assign accept   = rd_q & ~drop;
  assign push     = accept & (rd_idx == 2'd3);

  // Next-state and issue decode
  always_comb begin
    state_nxt  = state;
    im_rd      = 1'b0;
    credit_nxt = credit;

    case ({pop, issue_b0})
      2'b10:   credit_nxt = credit + CW'(1);
      2'b01:   credit_nxt = credit - CW'(1);
      default: credit_nxt = credit;
    endcase

    if (run) begin
      case (state)
        ST_ISSUE: begin
          if (bcnt != 2'd0 || credit != '0) im_rd = 1'b1;
          else state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (credit_nxt != '0) state_nxt = ST_ISSUE;
        end
        default: state_nxt = ST_ISSUE;
      endcase
    end

    if (redirect) begin
      state_nxt  = ST_ISSUE;
      credit_nxt = CW'(DEPTH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_ISSUE;
      credit <= CW'(DEPTH);
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
    end
  end

  // Fetch counters, return path and queue control
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run     <= 1'b0;
      fpc     <= RESET_PC;
      bcnt    <= 2'd0;
      drop    <= 1'b0;
      sr      <= 24'h0;
      rd_q    <= 1'b0;
      rd_idx  <= 2'd0;
      word_pc <= 32'h0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      run    <= 1'b1;
      rd_q   <= im_rd;
      rd_idx <= bcnt;
      drop   <= redirect;

      if (redirect) begin
        fpc   <= redirect_pc & ~32'h3;
        bcnt  <= 2'd0;
        sr    <= 24'h0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (im_rd) begin
          if (bcnt == 2'd0) word_pc <= fpc;
          if (bcnt == 2'd3) begin
            fpc  <= fpc + 32'd4;
            bcnt <= 2'd0;
          end else begin
            bcnt <= bcnt + 2'd1;
          end
        end

        if (accept) sr <= {sr[15:0], im_rdata};

        if (push) tail <= ptr_inc(tail);
        if (pop)  head <= ptr_inc(head);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage; contents are masked by inst_valid so no reset is needed
  always_ff @(posedge clk) begin
    if (rst_n && !redirect && push) begin
      q_inst[tail] <= {sr, im_rdata};
      q_pc[tail]   <= word_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a byte-wide instruction memory model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        im_rd;
  logic [4:0]  im_addr;
  logic [7:0]  im_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic [7:0]  mem [0:31];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rd_cnt;

  ifetch_unit #(.ADDR_W(5), .DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .im_rd       (im_rd),
    .im_addr     (im_addr),
    .im_rdata    (im_rdata),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (im_rd) im_rdata <= mem[im_addr];
    else       im_rdata <= 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
    cyc++;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) nc();
  endtask

  // Holds reset, checks reset outputs, releases; returns at negedge of cycle 0
  task automatic start();
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    inst_ready = 1'b0;
    nc();
    nc();
    chk("rst_im_rd", {31'h0, im_rd}, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    rst_n = 1'b1;
    nc();
    cyc = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'h8C; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h04;
    mem[4] = 8'h00; mem[5] = 8'h22; mem[6] = 8'h18; mem[7] = 8'h20;
    mem[16] = 8'hDE; mem[17] = 8'hAD; mem[18] = 8'hBE; mem[19] = 8'hEF;
    mem[28] = 8'h11; mem[29] = 8'h22; mem[30] = 8'h33; mem[31] = 8'h44;
    rst_n = 1'b0;
    inst_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    nc();

    // Sequential fetch
    start();
    inst_ready = 1'b1;
    chk("seq_rd_c0", {31'h0, im_rd}, 32'h1);
    chk("seq_addr_c0", {27'h0, im_addr}, 32'h0);
    go_to(3);
    chk("seq_addr_c3", {27'h0, im_addr}, 32'h3);
    go_to(4);
    chk("seq_valid_c4", {31'h0, inst_valid}, 32'h0);
    go_to(5);
    chk("seq_valid_c5", {31'h0, inst_valid}, 32'h1);
    chk("seq_inst_c5", inst, 32'h8C010004);
    chk("seq_pc_c5", inst_pc, 32'h0);
    go_to(9);
    chk("seq_inst_c9", inst, 32'h00221820);
    chk("seq_pc_c9", inst_pc, 32'h4);

    // Backpressure
    start();
    rd_cnt = 0;
    while (cyc < 20) begin
      rd_cnt += int'(im_rd);
      if (cyc == 7) chk("bp_rd_c7", {31'h0, im_rd}, 32'h1);
      if (cyc == 8) chk("bp_rd_c8", {31'h0, im_rd}, 32'h0);
      nc();
    end
    chk("bp_rd_count", rd_cnt, 32'd8);
    chk("bp_hold_inst", inst, 32'h8C010004);
    chk("bp_rd_c20", {31'h0, im_rd}, 32'h0);
    inst_ready = 1'b1;
    nc();
    chk("bp_inst_c21", inst, 32'h00221820);
    chk("bp_pc_c21", inst_pc, 32'h4);
    chk("bp_rd_c21", {31'h0, im_rd}, 32'h1);
    chk("bp_addr_c21", {27'h0, im_addr}, 32'h8);
    inst_ready = 1'b0;

    // Mid-word redirect
    start();
    go_to(6);
    redirect = 1'b1;
    redirect_pc = 32'h10;
    nc();
    redirect = 1'b0;
    chk("rd_valid_c7", {31'h0, inst_valid}, 32'h0);
    chk("rd_addr_c7", {27'h0, im_addr}, 32'h10);
    chk("rd_rd_c7", {31'h0, im_rd}, 32'h1);
    go_to(11);
    chk("rd_valid_c11", {31'h0, inst_valid}, 32'h0);
    go_to(12);
    chk("rd_inst_c12", inst, 32'hDEADBEEF);
    chk("rd_pc_c12", inst_pc, 32'h10);

    // Address wrap (redirect in cycle 12)
    inst_ready = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h1C;
    nc();
    redirect = 1'b0;
    chk("wr_addr_1c", {27'h0, im_addr}, 32'h1C);
    go_to(16);
    chk("wr_addr_1f", {27'h0, im_addr}, 32'h1F);
    go_to(17);
    chk("wr_addr_00", {27'h0, im_addr}, 32'h00);
    go_to(18);
    chk("wr_inst_1c", inst, 32'h11223344);
    chk("wr_pc_1c", inst_pc, 32'h1C);
    go_to(20);
    chk("wr_addr_03", {27'h0, im_addr}, 32'h03);
    go_to(22);
    chk("wr_valid_20", {31'h0, inst_valid}, 32'h1);
    chk("wr_inst_20", inst, 32'h8C010004);
    chk("wr_pc_20", inst_pc, 32'h20);

    // Misaligned target (redirect in cycle 22)
    redirect = 1'b1;
    redirect_pc = 32'h13;
    nc();
    redirect = 1'b0;
    chk("ma_addr_10", {27'h0, im_addr}, 32'h10);
    go_to(26);
    chk("ma_addr_13", {27'h0, im_addr}, 32'h13);
    go_to(28);
    chk("ma_inst", inst, 32'hDEADBEEF);
    chk("ma_pc", inst_pc, 32'h10);

    // Mid-operation reset
    start();
    inst_ready = 1'b1;
    go_to(9);
    chk("mr_inst_c9", inst, 32'h00221820);
    go_to(10);
    rst_n = 1'b0;
    nc();
    rst_n = 1'b1;
    chk("mr_rd_c11", {31'h0, im_rd}, 32'h0);
    chk("mr_addr_c11", {27'h0, im_addr}, 32'h0);
    chk("mr_valid_c11", {31'h0, inst_valid}, 32'h0);
    chk("mr_inst_c11", inst, 32'h0);
    chk("mr_pc_c11", inst_pc, 32'h0);
    nc();
    chk("mr_rd_c12", {31'h0, im_rd}, 32'h1);
    chk("mr_addr_c12", {27'h0, im_addr}, 32'h0);
    go_to(16);
    chk("mr_valid_c16", {31'h0, inst_valid}, 32'h0);
    go_to(17);
    chk("mr_valid_c17", {31'h0, inst_valid}, 32'h1);
    chk("mr_inst_c17", inst, 32'h8C010004);
    chk("mr_pc_c17", inst_pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage placed directly upstream of the single-cycle datapath's decode/execute logic. It reads the byte-wide instruction memory one byte per cycle and assembles big-endian 32-bit instruction words (lowest address in bits 31:24). It buffers up to DEPTH words with their PCs and hands them to the datapath over a valid/ready handshake. Branch and jump targets arrive on a redirect port, which flushes all buffered and in-flight work.

## Interface
- ADDR_W, 5: instruction memory byte-address width; 32 bytes by default.
- DEPTH, 2: prefetch queue depth in words; must be ≥1.
- RESET_PC, 32'h0: fetch PC after reset; must be word-aligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- im_rd  out  1  byte read strobe to instruction memory.
- im_addr  out  ADDR_W  byte address for this cycle's read.
- im_rdata  in  8  read data; valid in the cycle after the im_rd cycle.
- inst  out  32  instruction at queue head.
- inst_pc  out  32  byte PC of inst.
- inst_valid  out  1  queue non-empty.
- inst_ready  in  1  consumer accepts the head word when inst_valid & inst_ready.
- redirect  in  1  load a new fetch PC and flush.
- redirect_pc  in  32  target; bits 1:0 are ignored and treated as 00.

## Operation
- State registers:
  - run bit.
  - fpc (32-bit word PC).
  - bcnt (0..3).
  - FSM {WAIT, ISSUE}.
  - credit (0..DEPTH).
  - drop flag.
  - Byte shift register.
  - Queue of DEPTH {inst, pc} entries, with head/tail pointers and count.
- Reset (rst_n sampled low at an edge), effective from the next edge:
  - run=0, fpc=RESET_PC, bcnt=0, FSM=ISSUE, credit=DEPTH, drop=0, queue empty.
  - Outputs: im_rd=0, im_addr=0, inst=0, inst_pc=0, inst_valid=0.
  - Reset mid-operation discards everything, including bytes in flight.
- run is set at the first edge that samples rst_n high. im_rd is 0 whenever run=0.
- ISSUE issue rule:
  - im_rd=1 when bcnt≠0, or when bcnt=0 and credit>0.
  - im_addr = (fpc + bcnt) mod 2^ADDR_W.
  - If bcnt=0, credit>0 is false, and the FSM is in ISSUE, it moves to WAIT with im_rd=0.
- Counters on each issue:
  - An issue with bcnt=0 decrements credit and latches the word PC = fpc.
  - An issue with bcnt=3 adds 4 to fpc (32-bit wrap) and returns bcnt to 0.
- WAIT returns to ISSUE at the edge where credit becomes >0.
- Return path:
  - When drop=0, each returning byte shifts into the assembly register.
  - The 4th byte of a word is combined with the three held bytes and pushed into the queue tail at the same edge.
- Credit:
  - A pop (inst_valid & inst_ready) increments credit at the edge.
  - A pop and a byte-0 issue in the same cycle leave credit unchanged.
  - Credit is registered, so a pop does not enable an issue in the same cycle.
- Redirect (sampled at an edge, highest priority after reset):
  - Queue flushed; a handshake completing in that same cycle still counts as consumed.
  - Partial assembly discarded.
  - fpc = {redirect_pc[31:2], 2'b00}, bcnt=0, credit=DEPTH, FSM=ISSUE.
  - drop=1 for exactly one cycle, discarding the byte returning for the redirect-cycle issue.
- inst and inst_pc show the queue head and are stable while inst_valid & !inst_ready. They are don't-care when inst_valid=0, except 0 after reset.
- Instruction memory address wraps modulo 2^ADDR_W. inst_pc does not wrap at 2^ADDR_W.

## Timing
- Cycle 0 is the first cycle with run=1. Byte-0 issue is in cycle 0, and the first inst_valid is in cycle 5.
- Steady state with inst_ready=1: one word per 4 cycles; im_rd is continuously 1.
- Redirect sampled at the end of cycle r:
  - inst_valid=0 in cycle r+1.
  - First issue in cycle r+1 at the new address.
  - New word valid in cycle r+6.
- Queue full with inst_ready=0: at most DEPTH words are reserved, and im_rd stays 0 until a pop restores credit.

## Test plan
- Sequential fetch: reset, inst_ready=1, IM[0..7]=8C 01 00 04 00 22 18 20 → inst=8C010004, pc=0 in cycle 5; inst=00221820, pc=4 in cycle 9.
- Backpressure:
  - Setup: inst_ready=0.
  - Expected: im_rd=1 in cycles 0–7, then 0. Queue holds 2 words; inst holds 8C010004.
  - Release: inst_ready=1 in cycle 20 → inst=00221820 in cycle 21, im_rd=1 again in cycle 21.
- Mid-word redirect:
  - Stimulus: redirect=1, redirect_pc=0x10 in cycle 6, inst_ready=0.
  - Expected in cycle 7: inst_valid=0, im_addr=0x10, returning byte ignored.
  - Expected in cycle 12: inst = IM[0x10..0x13], pc=0x10.
- Address wrap: redirect_pc=0x1C, ADDR_W=5 → bytes read from 0x1C–0x1F; the next word uses im_addr 0x00–0x03 with inst_pc=0x20.
- Misaligned target: redirect_pc=0x13 → im_addr sequence 0x10..0x13; inst_pc=0x10.
- Mid-operation reset: rst_n=0 during cycle 10 → cycle 11 has all outputs at reset values with im_rd=0. Refetch from RESET_PC; im_rd=1 in cycle 12; inst_valid in cycle 17.
